// File: rtl/rand_range_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rand_range_sampler_pkg
// Description : Shared constants and state type for the range sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package rand_range_sampler_pkg;

  // Default operand width, matching the free-running LFSR.
  localparam int C_WORD_WIDTH = 512;

  // Sampler FSM states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_SAMPLE = 2'd2,
    S_HOLD   = 2'd3
  } smp_state_t;

endpackage
`default_nettype wire

// File: rtl/rand_range_sampler_msb_smear.sv
`default_nettype none
// ============================================================================
// Module      : msb_smear
// Description : Output bit i is the OR of input bits [WIDTH-1:i], i.e. every
//               bit at or below the highest set bit becomes one. Built as a
//               log-depth shift-OR ladder.
// Revision    : 1.0 - initial release
// ============================================================================
module msb_smear #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_mask
);

  localparam int C_LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Each stage ORs in a copy shifted down by twice the previous distance.
  generate
    for (genvar k = 0; k < C_LEVELS; k++) begin : g_stage
      logic [WIDTH-1:0] w_prev;
      logic [WIDTH-1:0] w_acc;
      if (k == 0) begin : g_first
        assign w_prev = i_vec;
      end else begin : g_next
        assign w_prev = g_stage[k-1].w_acc;
      end
      assign w_acc = w_prev | (w_prev >> (1 << k));
    end
  endgenerate

  assign o_mask = g_stage[C_LEVELS-1].w_acc;

endmodule
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : rand_range_sampler
// Description : Draws a value uniformly from [2, n-2] out of the LFSR word by
//               mask-and-reject sampling with a bounded number of retries.
//               Not cryptographically secure.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_range_sampler
  import rand_range_sampler_pkg::*;
#(
  parameter int WORD_WIDTH  = C_WORD_WIDTH,
  parameter int MAX_TRIES   = 64,
  parameter int DRAW_STRIDE = 1,
  parameter int TRY_W       = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] rand_in,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] bound,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] rand_out,
  output logic                  fail,
  output logic [TRY_W-1:0]      tries
);

  localparam int                    C_STR_W         = (DRAW_STRIDE > 1) ? $clog2(DRAW_STRIDE) : 1;
  localparam logic [C_STR_W-1:0]    C_STRIDE_RELOAD = C_STR_W'(DRAW_STRIDE - 1);
  localparam logic [TRY_W-1:0]      C_MAX_TRIES     = TRY_W'(MAX_TRIES);
  localparam logic [WORD_WIDTH-1:0] C_FOUR          = WORD_WIDTH'(4);
  localparam logic [WORD_WIDTH-1:0] C_TWO           = WORD_WIDTH'(2);

  smp_state_t             state_q, state_d;
  logic [WORD_WIDTH-1:0]  n_q, n_d;
  logic [WORD_WIDTH-1:0]  lim_q, lim_d;
  logic [WORD_WIDTH-1:0]  mask_q, mask_d;
  logic [C_STR_W-1:0]     stride_q, stride_d;
  logic [TRY_W-1:0]       tries_q, tries_d;
  logic [WORD_WIDTH-1:0]  rand_out_q, rand_out_d;
  logic                   fail_q, fail_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic [WORD_WIDTH-1:0]  w_lim;
  logic [WORD_WIDTH-1:0]  w_mask;
  logic [WORD_WIDTH-1:0]  w_draw;
  logic [TRY_W-1:0]       w_tries_inc;

  // Largest accepted raw draw is n-4, so that draw+2 lands at most on n-2.
  assign w_lim       = n_q - C_FOUR;
  assign w_draw      = rand_in & mask_q;
  assign w_tries_inc = tries_q + TRY_W'(1);

  msb_smear #(
    .WIDTH (WORD_WIDTH)
  ) u_msb_smear (
    .i_vec  (w_lim),
    .o_mask (w_mask)
  );

  // Next-state and datapath update for the IDLE/SETUP/SAMPLE/HOLD sequence.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    lim_d      = lim_q;
    mask_d     = mask_q;
    stride_d   = stride_q;
    tries_d    = tries_q;
    rand_out_d = rand_out_q;
    fail_d     = fail_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = bound;
          tries_d = '0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (n_q < C_FOUR) begin
          // Range [2, n-2] is empty: report failure without drawing.
          rand_out_d = '0;
          fail_d     = 1'b1;
          valid_d    = 1'b1;
          state_d    = S_HOLD;
        end else begin
          lim_d    = w_lim;
          mask_d   = w_mask;
          stride_d = '0;
          state_d  = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (stride_q == '0) begin
          stride_d = C_STRIDE_RELOAD;
          if (w_draw <= lim_q) begin
            rand_out_d = w_draw + C_TWO;
            fail_d     = 1'b0;
            valid_d    = 1'b1;
            state_d    = S_HOLD;
          end else begin
            tries_d = w_tries_inc;
            if (w_tries_inc == C_MAX_TRIES) begin
              rand_out_d = '0;
              fail_d     = 1'b1;
              valid_d    = 1'b1;
              state_d    = S_HOLD;
            end
          end
        end else begin
          stride_d = stride_q - C_STR_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any draw in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      lim_q      <= '0;
      mask_q     <= '0;
      stride_q   <= '0;
      tries_q    <= '0;
      rand_out_q <= '0;
      fail_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      lim_q      <= lim_d;
      mask_q     <= mask_d;
      stride_q   <= stride_d;
      tries_q    <= tries_d;
      rand_out_q <= rand_out_d;
      fail_q     <= fail_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign rand_out  = rand_out_q;
  assign fail      = fail_q;
  assign tries     = tries_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_range_sampler
// Description : Self-checking bench for rand_range_sampler at 16-bit width,
//               with three parameterisations (default, MAX_TRIES=4,
//               DRAW_STRIDE=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_range_sampler;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_ab;
  logic         rst_c;
  logic [W-1:0] rand_in;
  logic [W-1:0] bound;
  logic         start;
  logic         out_ready;
  logic [1:0]   sel;

  logic         a_busy, a_valid, a_fail;
  logic [W-1:0] a_out;
  logic [6:0]   a_tries;
  logic         b_busy, b_valid, b_fail;
  logic [W-1:0] b_out;
  logic [2:0]   b_tries;
  logic         c_busy, c_valid, c_fail;
  logic [W-1:0] c_out;
  logic [6:0]   c_tries;

  int o_busy, o_valid, o_out, o_fail, o_tries;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] w [0:79];

  always #5 clk = ~clk;

  rand_range_sampler #(.WORD_WIDTH(W), .MAX_TRIES(64), .DRAW_STRIDE(1)) dut_a (
    .clk(clk), .rst(rst_ab), .rand_in(rand_in), .start(start && sel == 2'd0), .bound(bound),
    .busy(a_busy), .out_valid(a_valid), .out_ready(out_ready && sel == 2'd0),
    .rand_out(a_out), .fail(a_fail), .tries(a_tries));

  rand_range_sampler #(.WORD_WIDTH(W), .MAX_TRIES(4), .DRAW_STRIDE(1)) dut_b (
    .clk(clk), .rst(rst_ab), .rand_in(rand_in), .start(start && sel == 2'd1), .bound(bound),
    .busy(b_busy), .out_valid(b_valid), .out_ready(out_ready && sel == 2'd1),
    .rand_out(b_out), .fail(b_fail), .tries(b_tries));

  rand_range_sampler #(.WORD_WIDTH(W), .MAX_TRIES(64), .DRAW_STRIDE(3)) dut_c (
    .clk(clk), .rst(rst_c), .rand_in(rand_in), .start(start && sel == 2'd2), .bound(bound),
    .busy(c_busy), .out_valid(c_valid), .out_ready(out_ready && sel == 2'd2),
    .rand_out(c_out), .fail(c_fail), .tries(c_tries));

  // Observe whichever instance is currently selected.
  always_comb begin
    o_busy = 0; o_valid = 0; o_out = 0; o_fail = 0; o_tries = 0;
    case (sel)
      2'd0: begin o_busy = int'(a_busy); o_valid = int'(a_valid); o_out = int'(a_out); o_fail = int'(a_fail); o_tries = int'(a_tries); end
      2'd1: begin o_busy = int'(b_busy); o_valid = int'(b_valid); o_out = int'(b_out); o_fail = int'(b_fail); o_tries = int'(b_tries); end
      default: begin o_busy = int'(c_busy); o_valid = int'(c_valid); o_out = int'(c_out); o_fail = int'(c_fail); o_tries = int'(c_tries); end
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: the draw j happens on edge 3+stride*j counted from the start
  // capture edge; the mask is the smallest all-ones value covering n-4.
  function automatic void model(input int n, input int maxt, input int stride,
                                output int e_edge, output int e_out,
                                output int e_fail, output int e_tries);
    int lim, mask, r;
    bit done;
    done = 1'b0;
    e_edge = 0; e_out = 0; e_fail = 0; e_tries = 0;
    if (n < 4) begin
      e_edge = 2; e_out = 0; e_fail = 1; e_tries = 0;
    end else begin
      lim  = n - 4;
      mask = 0;
      while (mask < lim) mask = mask * 2 + 1;
      for (int j = 0; j < maxt; j++) begin
        if (!done) begin
          r = int'(w[j]) & mask;
          if (r <= lim) begin
            done = 1'b1;
            e_edge = 3 + stride * j; e_out = r + 2; e_fail = 0; e_tries = j;
          end
        end
      end
      if (!done) begin
        e_edge = 3 + stride * (maxt - 1); e_out = 0; e_fail = 1; e_tries = maxt;
      end
    end
  endfunction

  // Start a draw on instance s and follow it until out_valid; call at a negedge.
  task automatic run(input logic [1:0] s, input int n, input int stride,
                     output int g_edge, output int g_out, output int g_fail,
                     output int g_tries, output int g_busy);
    int m, j;
    sel = s; bound = W'(n); start = 1'b1; rand_in = w[0];
    g_edge = -1; g_out = -1; g_fail = -1; g_tries = -1; g_busy = -1;
    @(posedge clk);
    m = 1;
    while (m < 300) begin
      @(negedge clk);
      start = 1'b0;
      if (m == 1) g_busy = o_busy;
      if (o_valid != 0) begin
        g_edge = m; g_out = o_out; g_fail = o_fail; g_tries = o_tries;
        break;
      end
      j = (m <= 2) ? 0 : ((m - 2) + stride - 1) / stride;
      if (j > 79) j = 79;
      rand_in = w[j];
      @(posedge clk);
      m++;
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_busy_released"}, o_busy, 0);
    chk({name, "_valid_dropped"}, o_valid, 0);
  endtask

  typedef struct {
    logic [1:0]   s;
    int           stride;
    int           n;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           e_edge;
    int           e_out;
    int           e_fail;
    int           e_tries;
  } vec_t;

  vec_t tbl [0:8];

  initial begin
    int ge, go, gf, gt, gb;
    int ee, eo, ef, et, n, maxt, stride;
    logic [1:0] s;

    rst_ab = 1'b0; rst_c = 1'b0; start = 1'b0; out_ready = 1'b0;
    sel = 2'd0; bound = '0; rand_in = '0;
    for (int i = 0; i < 80; i++) w[i] = '0;

    tbl[0] = '{2'd0, 1, 11,    16'h0005, 16'h0005, 3, 7,      0, 0};
    tbl[1] = '{2'd0, 1, 12,    16'h000E, 16'h0004, 4, 6,      0, 1};
    tbl[2] = '{2'd0, 1, 3,     16'h1234, 16'h1234, 2, 0,      1, 0};
    tbl[3] = '{2'd0, 1, 4,     16'hBEEF, 16'hBEEF, 3, 2,      0, 0};
    tbl[4] = '{2'd1, 1, 12,    16'hFFFF, 16'hFFFF, 6, 0,      1, 4};
    tbl[5] = '{2'd0, 1, 0,     16'h0001, 16'h0001, 2, 0,      1, 0};
    tbl[6] = '{2'd0, 1, 65535, 16'hFFFC, 16'hFFFB, 4, 65533,  0, 1};
    tbl[7] = '{2'd2, 3, 12,    16'h000E, 16'h0004, 6, 6,      0, 1};
    tbl[8] = '{2'd2, 3, 11,    16'h0005, 16'h0005, 3, 7,      0, 0};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_busy", o_busy, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_out", o_out, 0);
    chk("reset_fail", o_fail, 0);
    chk("reset_tries", o_tries, 0);
    rst_ab = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int k = 0; k <= 8; k++) begin
      w[0] = tbl[k].w0;
      for (int i = 1; i < 80; i++) w[i] = tbl[k].w1;
      run(tbl[k].s, tbl[k].n, tbl[k].stride, ge, go, gf, gt, gb);
      chk($sformatf("tbl%0d_edge", k), ge, tbl[k].e_edge);
      chk($sformatf("tbl%0d_out", k), go, tbl[k].e_out);
      chk($sformatf("tbl%0d_fail", k), gf, tbl[k].e_fail);
      chk($sformatf("tbl%0d_tries", k), gt, tbl[k].e_tries);
      chk($sformatf("tbl%0d_busy", k), gb, 1);
      handshake($sformatf("tbl%0d", k));
    end

    // Result held while out_ready is low; start pulses are ignored.
    for (int i = 0; i < 80; i++) w[i] = 16'h0005;
    run(2'd0, 11, 1, ge, go, gf, gt, gb);
    chk("hold_edge", ge, 3);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2); bound = 16'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("hold%0d_valid", c), o_valid, 1);
      chk($sformatf("hold%0d_out", c), o_out, 7);
      chk($sformatf("hold%0d_busy", c), o_busy, 1);
      chk($sformatf("hold%0d_tries", c), o_tries, 0);
    end
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    chk("hs_busy", o_busy, 0);
    chk("hs_valid", o_valid, 0);
    chk("hs_out_kept", o_out, 7);
    @(posedge clk);
    @(negedge clk);
    chk("hs_start_ignored", o_busy, 0);

    // Reset mid-SAMPLE on the strided instance.
    w[0] = 16'h000E;
    for (int i = 1; i < 80; i++) w[i] = 16'h0004;
    sel = 2'd2; bound = 16'd12; start = 1'b1; rand_in = w[0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_tries", o_tries, 1);
    rst_c = 1'b0;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_out", o_out, 0);
    chk("abort_fail", o_fail, 0);
    chk("abort_tries", o_tries, 0);
    @(negedge clk);
    rst_c = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 80; i++) w[i] = 16'h0003;
    run(2'd2, 11, 3, ge, go, gf, gt, gb);
    chk("restart_edge", ge, 3);
    chk("restart_out", go, 5);
    chk("restart_fail", gf, 0);
    handshake("restart");

    // Randomized draws against the reference model.
    for (int it = 0; it < 36; it++) begin
      s = 2'(it % 3);
      maxt   = (s == 2'd1) ? 4 : 64;
      stride = (s == 2'd2) ? 3 : 1;
      case ($urandom_range(0, 3))
        0:       n = int'($urandom_range(0, 20));
        1:       n = int'($urandom_range(5, 40));
        default: n = int'($urandom_range(0, 65535));
      endcase
      for (int i = 0; i < 80; i++) w[i] = W'($urandom);
      model(n, maxt, stride, ee, eo, ef, et);
      run(s, n, stride, ge, go, gf, gt, gb);
      chk($sformatf("rnd%0d_n%0d_edge", it, n), ge, ee);
      chk($sformatf("rnd%0d_n%0d_out", it, n), go, eo);
      chk($sformatf("rnd%0d_n%0d_fail", it, n), gf, ef);
      chk($sformatf("rnd%0d_n%0d_tries", it, n), gt, et);
      handshake($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
